// File: rtl/ili9341_pkg.sv
// ili9341_pkg: shared constants and types for the ILI9341 SPI bus arbiter.
//   BIT_PERIOD   - clk cycles per SPI bit (low phase + high phase)
//   BYTE_CYCLES  - clk cycles per serialised byte
//   DC_CMD/DC_DATA - panel D/C line levels
//   arb_state_e  - arbiter FSM encoding
//   hold_t       - one-byte/one-word holding register payload
package ili9341_pkg;

    localparam int unsigned BIT_PERIOD    = 2;
    localparam int unsigned BITS_PER_BYTE = 8;
    localparam int unsigned BYTE_CYCLES   = BIT_PERIOD * BITS_PER_BYTE;
    localparam int unsigned CNT_W         = $clog2(BYTE_CYCLES);
    localparam int unsigned HOLD_DATA_W   = 16;
    localparam int unsigned HOLD_CNT_W    = 2;

    localparam logic DC_CMD  = 1'b0;
    localparam logic DC_DATA = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } arb_state_e;

    typedef enum logic {
        OWN_CMD = 1'b0,
        OWN_PIX = 1'b1
    } owner_e;

    // Bytes still to be sent are kept MSB-aligned in data; nbytes = 0 means empty.
    typedef struct packed {
        logic [HOLD_DATA_W-1:0] data;
        logic [HOLD_CNT_W-1:0]  nbytes;
        logic                   dc;
    } hold_t;

endpackage

// File: rtl/ili9341_spi_shifter.sv
// ili9341_spi_shifter: SPI mode-0 byte serialiser, MSB first.
//   clk, rst       - clock, synchronous active-high reset
//   load           - start a new byte this cycle (load_byte, load_dc)
//   sclk/sdin/sdc  - registered SPI clock, data and D/C level
//   active         - a byte is being shifted
//   last_cycle_c   - final (high-phase) cycle of the current byte
module ili9341_spi_shifter
    import ili9341_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] load_byte,
    input  logic       load_dc,
    output logic       sclk,
    output logic       sdin,
    output logic       sdc,
    output logic       active,
    output logic       last_cycle_c
);

    logic [7:0]       shreg_q, shreg_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             active_q, active_d;
    logic             sclk_q, sclk_d;
    logic             dc_q, dc_d;

    // Even count = clock low with bit presented, odd count = clock high.
    always_comb begin
        shreg_d  = shreg_q;
        cnt_d    = cnt_q;
        active_d = active_q;
        dc_d     = dc_q;

        last_cycle_c = active_q && (cnt_q == CNT_W'(BYTE_CYCLES - 1));

        if (active_q) begin
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q[0]) begin
                shreg_d = {shreg_q[6:0], 1'b0};
            end
            if (last_cycle_c) begin
                active_d = 1'b0;
            end
        end

        // A load on the last cycle chains the next byte with no gap.
        if (load) begin
            shreg_d  = load_byte;
            dc_d     = load_dc;
            cnt_d    = '0;
            active_d = 1'b1;
        end

        sclk_d = active_d & cnt_d[0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shreg_q  <= '0;
            cnt_q    <= '0;
            active_q <= 1'b0;
            sclk_q   <= 1'b0;
            dc_q     <= DC_CMD;
        end else begin
            shreg_q  <= shreg_d;
            cnt_q    <= cnt_d;
            active_q <= active_d;
            sclk_q   <= sclk_d;
            dc_q     <= dc_d;
        end
    end

    assign sclk   = sclk_q;
    assign sdin   = shreg_q[7];
    assign sdc    = dc_q;
    assign active = active_q;

endmodule

// File: rtl/ili9341_bus_arbiter.sv
// ili9341_bus_arbiter: shares one ILI9341 SPI bus between a command-byte port
// and an RGB565 pixel port, fixed priority to commands, no preemption.
//   HOLD_CYCLES             - cycles tft_cs stays high after a transaction (>= 1)
//   clk, rst                - clock, synchronous active-high reset
//   init_done               - new grants allowed only while high
//   cmd_valid/ready/byte/dc/last - command byte stream
//   pix_valid/ready/data/last    - pixel word stream (sent high byte first)
//   tft_cs/dc/clk/din       - panel SPI lines
//   busy                    - transaction or CS hold in progress
module ili9341_bus_arbiter
    import ili9341_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        init_done,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [7:0]  cmd_byte,
    input  logic        cmd_dc,
    input  logic        cmd_last,
    input  logic        pix_valid,
    output logic        pix_ready,
    input  logic [15:0] pix_data,
    input  logic        pix_last,
    output logic        tft_cs,
    output logic        tft_dc,
    output logic        tft_clk,
    output logic        tft_din,
    output logic        busy
);

    localparam int unsigned HCNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    arb_state_e        state_q, state_d;
    owner_e            owner_q, owner_d;
    hold_t             hold_q, hold_d;
    logic              last_seen_q, last_seen_d;
    logic [HCNT_W-1:0] hcnt_q, hcnt_d;
    logic              cs_q, cs_d;
    logic              busy_q, busy_d;

    logic              cmd_ready_c, pix_ready_c;
    logic              sh_load_c;
    logic [7:0]        sh_byte_c;
    logic              sh_dc_c;
    logic              sh_active;
    logic              sh_last_c;
    logic              hold_empty_c;
    logic              byte_slot_c;

    // Arbitration, holding-register management and FSM next state.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        hold_d       = hold_q;
        last_seen_d  = last_seen_q;
        hcnt_d       = hcnt_q;
        cmd_ready_c  = 1'b0;
        pix_ready_c  = 1'b0;
        sh_load_c    = 1'b0;
        sh_byte_c    = '0;
        sh_dc_c      = DC_CMD;
        hold_empty_c = (hold_q.nbytes == '0);
        byte_slot_c  = sh_last_c || !sh_active;

        case (state_q)
            IDLE: begin
                // The first byte goes straight to the shifter so the bus starts next cycle.
                if (init_done && !rst) begin
                    if (cmd_valid) begin
                        cmd_ready_c = 1'b1;
                        sh_load_c   = 1'b1;
                        sh_byte_c   = cmd_byte;
                        sh_dc_c     = cmd_dc;
                        owner_d     = OWN_CMD;
                        hold_d      = '0;
                        last_seen_d = cmd_last;
                        state_d     = SHIFT;
                    end else if (pix_valid) begin
                        pix_ready_c   = 1'b1;
                        sh_load_c     = 1'b1;
                        sh_byte_c     = pix_data[15:8];
                        sh_dc_c       = DC_DATA;
                        owner_d       = OWN_PIX;
                        hold_d.data   = {pix_data[7:0], 8'h00};
                        hold_d.nbytes = HOLD_CNT_W'(1);
                        hold_d.dc     = DC_DATA;
                        last_seen_d   = pix_last;
                        state_d       = SHIFT;
                    end
                end
            end

            SHIFT: begin
                // Owner may refill only an empty register and only before its last item.
                if (hold_empty_c && !last_seen_q && !rst) begin
                    cmd_ready_c = (owner_q == OWN_CMD);
                    pix_ready_c = (owner_q == OWN_PIX);
                end

                if (cmd_valid && cmd_ready_c) begin
                    hold_d.data   = {cmd_byte, 8'h00};
                    hold_d.nbytes = HOLD_CNT_W'(1);
                    hold_d.dc     = cmd_dc;
                    last_seen_d   = cmd_last;
                end else if (pix_valid && pix_ready_c) begin
                    hold_d.data   = pix_data;
                    hold_d.nbytes = HOLD_CNT_W'(2);
                    hold_d.dc     = DC_DATA;
                    last_seen_d   = pix_last;
                end

                // Feed the shifter at a byte boundary or when it is stalled.
                if (!hold_empty_c && byte_slot_c) begin
                    sh_load_c     = 1'b1;
                    sh_byte_c     = hold_q.data[15:8];
                    sh_dc_c       = hold_q.dc;
                    hold_d.data   = {hold_q.data[7:0], 8'h00};
                    hold_d.nbytes = hold_q.nbytes - HOLD_CNT_W'(1);
                end else if (hold_empty_c && last_seen_q && byte_slot_c) begin
                    state_d = HOLD;
                    hcnt_d  = '0;
                end
            end

            HOLD: begin
                if (hcnt_q == HCNT_W'(HOLD_CYCLES - 1)) begin
                    state_d = IDLE;
                end else begin
                    hcnt_d = hcnt_q + HCNT_W'(1);
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        cs_d   = (state_d != SHIFT);
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            owner_q     <= OWN_CMD;
            hold_q      <= '0;
            last_seen_q <= 1'b0;
            hcnt_q      <= '0;
            cs_q        <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            hold_q      <= hold_d;
            last_seen_q <= last_seen_d;
            hcnt_q      <= hcnt_d;
            cs_q        <= cs_d;
            busy_q      <= busy_d;
        end
    end

    ili9341_spi_shifter u_shifter (
        .clk          (clk),
        .rst          (rst),
        .load         (sh_load_c),
        .load_byte    (sh_byte_c),
        .load_dc      (sh_dc_c),
        .sclk         (tft_clk),
        .sdin         (tft_din),
        .sdc          (tft_dc),
        .active       (sh_active),
        .last_cycle_c (sh_last_c)
    );

    // Ready follows valid in the grant cycle, so it cannot be a flop.
    assign cmd_ready = cmd_ready_c;
    assign pix_ready = pix_ready_c;
    assign tft_cs    = cs_q;
    assign busy      = busy_q;

endmodule

// File: doc/ili9341_bus_arbiter.md
ILI9341_BUS_ARBITER -- requirements
Module: ili9341_bus_arbiter

Interface
REQ-001 SHALL have parameter HOLD_CYCLES, default 2, minimum clk cycles tft_cs stays high between transactions.
REQ-002 SHALL have port clk  input  1  single clock; all logic on posedge clk.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port init_done  input  1  panel initialiser finished; no grant while low.
REQ-005 SHALL have ports cmd_valid/cmd_ready  in/out  1/1  command-port byte handshake.
REQ-006 SHALL have ports cmd_byte/cmd_dc/cmd_last  input  8/1/1  byte, D/C level (0=command), ends transaction.
REQ-007 SHALL have ports pix_valid/pix_ready  in/out  1/1  pixel-port handshake.
REQ-008 SHALL have ports pix_data/pix_last  input  16/1  RGB565 word, ends transaction.
REQ-009 SHALL have ports tft_cs/tft_dc/tft_clk/tft_din  output  1 each  panel SPI lines, mode 0, MSB first.
REQ-010 SHALL have port busy  output  1  high from grant until the end of CS hold.

Function
REQ-011 Transfer occurs on a port when valid and ready are both high at posedge clk.
REQ-012 Each bit SHALL take 2 cycles: tft_clk low with tft_din driven, then tft_clk high; a byte takes 16 cycles.
REQ-013 A pixel word SHALL be sent as 2 bytes, pix_data[15:8] then [7:0], with tft_dc=1.
REQ-014 Command bytes SHALL be sent with tft_dc=cmd_dc, latched at acceptance and held for the whole byte.
REQ-015 FSM states: IDLE, SHIFT, HOLD.
REQ-016 IDLE: if init_done, grant cmd if cmd_valid, else pix if pix_valid (fixed priority, cmd wins simultaneous requests).
REQ-017 The granted port's ready SHALL be high in IDLE for the cycle the port is granted; the other port's ready stays low.
REQ-018 Acceptance in IDLE -> SHIFT; tft_cs low, first bit on tft_din, in the next cycle (1-cycle latency).
REQ-019 The owner port SHALL be ready only while the one-byte/one-word holding register is empty; the non-owner is never ready during a transaction.
REQ-020 Holding register SHALL be loaded during the current byte so consecutive bytes of a transaction run with zero idle cycles and tft_cs stays low.
REQ-021 A transaction SHALL end after the byte/word accepted with last=1; then -> HOLD, tft_cs high, tft_clk low.
REQ-022 If the shifter finishes a byte while the holding register is empty and last not yet seen, it SHALL stall with tft_clk low, tft_cs low, until the owner supplies data.
REQ-023 HOLD SHALL last exactly HOLD_CYCLES cycles, then -> IDLE; no port is ready in HOLD.
REQ-024 init_done falling mid-transaction SHALL NOT abort it; it only blocks new grants.
REQ-025 Ownership SHALL never change between bytes of one transaction (no preemption).

Reset
REQ-026 rst SHALL force state IDLE, tft_cs=1, tft_clk=0, tft_din=0, tft_dc=0, busy=0, cmd_ready=0, pix_ready=0, holding register empty.
REQ-027 rst asserted mid-byte SHALL abandon the byte; outputs take reset values in the cycle after rst is sampled.

Structure
REQ-028 State encoding, bit-period constant (2), and D/C level names SHALL live in shared package ili9341_pkg.
REQ-029 Serialisation SHALL be one sub-module ili9341_spi_shifter (load byte+dc, 16-cycle shift, done pulse); arbitration and FSM stay in the top.

Verification
REQ-030 init_done=0, cmd_valid=1 for 50 cycles -> cmd_ready=0, tft_cs=1 throughout.
REQ-031 Single cmd 0x2A, dc=0, last=1 -> cs low 1 cycle after accept, din bits 0,0,1,0,1,0,1,0 sampled on 8 tft_clk rises, dc=0, cs high 16 cycles later for 2 cycles.
REQ-032 cmd_valid and pix_valid rise in the same IDLE cycle -> cmd granted first; pix granted only after cmd transaction plus 2-cycle HOLD.
REQ-033 Pixel burst 0xF800,0x07E0,last on 2nd word, valid held -> 32 contiguous tft_clk rises, cs low unbroken, dc=1, bytes F8 00 07 E0.
REQ-034 Owner valid withheld 10 cycles between bytes -> tft_clk low, cs low for the gap, shifting resumes with no corrupted bit.
REQ-035 rst pulsed at bit 4 of a byte -> next cycle cs=1, clk=0, busy=0; fresh cmd afterwards transmits correctly.
